// File: rtl/mat_pkg.sv
// Shared types and constants for the matrix stream reader.
package mat_pkg;

  // Reader control states, exposed on dbg_state for checkers.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

  // Output buffer depth; also the limit on buffered plus in-flight reads.
  localparam int READER_FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO carrying a data word plus a last flag, for stream blocks.
// The head (head_data/head_last) only changes on a pop or on a push into an
// empty FIFO, so it is stable while a consumer stalls.
module stream_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last
);

  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt_q;
  logic              do_push;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so push-while-full is legal with pop.
  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);
  assign count     = cnt_q;
  assign head_data = data_q[rd_ptr];
  assign head_last = last_q[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      last_q[0] <= 1'b0;
      last_q[1] <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr] <= push_data;
        last_q[wr_ptr] <= push_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mat_stream_reader.sv
// Streams a rows x cols tile out of a 1-cycle-latency RAM, in row-major or
// column-major order, with incremental address generation.
//
// Stream handshake: an element transfers in a cycle where out_valid and
// out_ready are both high. Once out_valid is raised, out_data/out_last/
// out_valid hold until that transfer happens; out_ready may change freely.
module mat_stream_reader
  import mat_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic              transpose,
  output logic              busy,
  output logic              done,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  reader_state_t     state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] col_base_q;
  logic [DIM_W-1:0]  rows_q;
  logic [DIM_W-1:0]  cols_q;
  logic              xpose_q;
  logic [DIM_W-1:0]  r_cnt;
  logic [DIM_W-1:0]  c_cnt;
  logic              rd_vld;
  logic              rd_last;

  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occ_sum;
  logic              issue_ok;
  logic              last_elem;

  // Buffered elements plus the read still in flight; a read may issue only
  // if its data is guaranteed a slot, counting this cycle's pop as a credit.
  assign pop       = out_valid && out_ready;
  assign occ_sum   = {1'b0, fifo_count} + {2'b00, rd_vld};
  assign issue_ok  = !fifo_full &&
                     (occ_sum < (3'(READER_FIFO_DEPTH) + {2'b00, pop}));
  assign mem_re    = (state == ST_ISSUE) && issue_ok;
  assign mem_addr  = addr_q;
  assign last_elem = (r_cnt == rows_q - DIM_W'(1)) && (c_cnt == cols_q - DIM_W'(1));
  assign out_valid = !fifo_empty;
  assign dbg_state = state;

  // Control FSM with address/index counters and read-return tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      addr_q     <= '0;
      col_base_q <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      xpose_q    <= 1'b0;
      r_cnt      <= '0;
      c_cnt      <= '0;
      rd_vld     <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_vld  <= mem_re;
      rd_last <= mem_re && last_elem;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            col_base_q <= base_addr;
            rows_q     <= rows;
            cols_q     <= cols;
            xpose_q    <= transpose;
            r_cnt      <= '0;
            c_cnt      <= '0;
            busy       <= 1'b1;
            state      <= (rows == '0 || cols == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_re) begin
            if (last_elem) begin
              state <= ST_DRAIN;
            end
            if (!xpose_q) begin
              // Row-major: column index is inner, addresses are contiguous.
              addr_q <= addr_q + ADDR_W'(1);
              if (c_cnt == cols_q - DIM_W'(1)) begin
                c_cnt <= '0;
                r_cnt <= r_cnt + DIM_W'(1);
              end else begin
                c_cnt <= c_cnt + DIM_W'(1);
              end
            end else begin
              // Column-major: step by the row stride, then restart one column over.
              if (r_cnt == rows_q - DIM_W'(1)) begin
                r_cnt      <= '0;
                c_cnt      <= c_cnt + DIM_W'(1);
                addr_q     <= col_base_q + ADDR_W'(1);
                col_base_q <= col_base_q + ADDR_W'(1);
              end else begin
                r_cnt  <= r_cnt + DIM_W'(1);
                addr_q <= addr_q + ADDR_W'(cols_q);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (!rd_vld && fifo_empty) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (rd_vld),
    .push_data (mem_rdata),
    .push_last (rd_last),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (out_data),
    .head_last (out_last)
  );

endmodule

// File: tb/tb_mat_stream_reader.sv
// Bench for mat_stream_reader: RAM model, address/data scoreboard,
// stall-stability and read-credit monitors, directed and random tiles.
module tb_mat_stream_reader;
  import mat_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [DIM_W-1:0]  rows = '0;
  logic [DIM_W-1:0]  cols = '0;
  logic              transpose = 1'b0;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy, done, mem_re, out_valid, out_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  int cyc = 0;
  int start_cyc, done_cyc, first_valid_cyc, re_first, re_last;
  int done_pulses, hs_count, re_count, busy_cycles, valid_cycles;
  int occ = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  logic prev_last;

  mat_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .rows      (rows),
    .cols      (cols),
    .transpose (transpose),
    .busy      (busy),
    .done      (done),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return {a ^ 16'h5A3C, ~a};
  endfunction

  // Synchronous RAM model, one cycle read latency.
  always @(posedge clock) if (mem_re) mem_rdata <= ram_word(mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: reads vs expected addresses, handshakes vs expected data.
  always @(negedge clock) begin
    logic [DATA_W:0] e;
    int pop_i;
    if (mon_en) begin
      pop_i = (out_valid && out_ready) ? 1 : 0;
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_data", out_data, prev_data);
        check_eq("stall_last", out_last, prev_last);
      end
      if (mem_re) begin
        check_eq("re_credit", ((occ - pop_i) < READER_FIFO_DEPTH) ? 1 : 0, 1);
        if (exp_addr_q.size() == 0) check_eq("re_extra", mem_addr, 'x);
        else check_eq("mem_addr", mem_addr, exp_addr_q.pop_front());
        if (re_first < 0) re_first = cyc;
        re_last = cyc;
        re_count++;
      end
      if (out_valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (pop_i == 1) begin
        if (exp_q.size() == 0) check_eq("hs_extra", out_data, 'x);
        else begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e[DATA_W-1:0]);
          check_eq("out_last", out_last, e[DATA_W]);
        end
        hs_count++;
      end
      if (busy) busy_cycles++;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) done_cyc = cyc;
        check_eq("done_busy", busy, 1'b0);
      end
      occ = occ + (mem_re ? 1 : 0) - pop_i;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return !(k >= 3 && k <= 8);
    endcase
  endfunction

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic last);
    exp_addr_q.push_back(a);
    exp_q.push_back({last, ram_word(a)});
  endtask

  // Driver: queue expectations, pulse start, run until done (bounded).
  task automatic run_tile(input logic [ADDR_W-1:0] b, input int r, input int c,
                          input logic t, input int mode, input int inject_k);
    int k;
    if (!t) begin
      for (int i = 0; i < r; i++)
        for (int j = 0; j < c; j++)
          push_exp(b + 16'(i * c + j), (i == r - 1) && (j == c - 1));
    end else begin
      for (int j = 0; j < c; j++)
        for (int i = 0; i < r; i++)
          push_exp(b + 16'(i * c + j), (i == r - 1) && (j == c - 1));
    end
    done_pulses = 0; hs_count = 0; re_count = 0; busy_cycles = 0; valid_cycles = 0;
    done_cyc = -1; first_valid_cyc = -1; re_first = -1; re_last = -1;
    @(posedge clock); #1;
    base_addr = b; rows = 8'(r); cols = 8'(c); transpose = t;
    start = 1'b1; start_cyc = cyc; out_ready = ready_for(mode, 0);
    k = 1;
    while (done_cyc < 0 && k < 400) begin
      @(posedge clock); #1;
      start = (k == inject_k);
      if (start) begin
        base_addr = 16'h0300; rows = 8'd2; cols = 8'd2; transpose = ~t;
      end
      out_ready = ready_for(mode, k);
      k++;
    end
    start = 1'b0;
    check_eq("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    repeat (2) @(posedge clock);
    #1;
    check_eq("hs_count", hs_count, r * c);
    check_eq("exp_left", exp_q.size(), 0);
    check_eq("addr_left", exp_addr_q.size(), 0);
    check_eq("done_pulses", done_pulses, 1);
    check_eq("busy_span", busy_cycles, done_cyc - start_cyc - 1);
  endtask

  // Main sequence.
  initial begin
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mem_re", mem_re, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 16'h0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_data", out_data, 32'h0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // Row-major 2x3.
    run_tile(16'h0010, 2, 3, 1'b0, 0, -1);
    check_eq("rm_first_re", re_first - start_cyc, 1);
    check_eq("rm_re_contig", re_last - re_first, 5);
    check_eq("rm_first_valid", first_valid_cyc - re_first, 2);

    // Column-major 2x3.
    run_tile(16'h0010, 2, 3, 1'b1, 0, -1);
    check_eq("cm_re_contig", re_last - re_first, 5);

    // Backpressure 3x3, ready low for cycles 3..8.
    run_tile(16'h0100, 3, 3, 1'b0, 2, -1);
    check_eq("bp_reads", re_count, 9);

    // Zero dimension.
    run_tile(16'h0200, 0, 5, 1'b0, 0, -1);
    check_eq("zero_re", re_count, 0);
    check_eq("zero_valid", valid_cycles, 0);
    check_eq("zero_done_lat", done_cyc - start_cyc, 2);

    // Address wrap with a stray start mid-tile.
    run_tile(16'hFFFE, 1, 4, 1'b0, 0, 2);

    // Asynchronous reset mid-tile.
    mon_en = 1'b0;
    @(posedge clock); #1;
    base_addr = 16'h0040; rows = 8'd3; cols = 8'd3; transpose = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_mem_re", mem_re, 1'b0);
    check_eq("mid_rst_mem_addr", mem_addr, 16'h0);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_last", out_last, 1'b0);
    check_eq("mid_rst_data", out_data, 32'h0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_state", dbg_state, ST_IDLE);
    @(posedge clock); #1 reset_n = 1'b1;
    exp_q.delete(); exp_addr_q.delete();
    occ = 0;
    mon_en = 1'b1;
    run_tile(16'h0020, 2, 2, 1'b0, 0, -1);

    // Random tiles with random backpressure.
    for (int n = 0; n < 500; n++) begin
      run_tile(16'($urandom_range(0, 65535)), $urandom_range(0, 4), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), 1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
